date_string_tx: RTL
===================

# date_string_tx

Transmitter counterpart of the date-string checker. Accepts a binary date (year, month, day, separator code) and serialises it one ASCII character per handshake as `Y{1-4}<sep>M{1-2}<sep>D{1-2}`, without leading zeros. Input fields are range-checked first, so every emitted string satisfies the checker's grammar. Typical use: checker stimulus source and date-stamp output stage.

## Interface
- `YEAR_W`, default 14: year input width; the accepted range is 1..9999.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; clock clk
- `start`  in  1  request pulse; sampled only while `busy`=0
- `year`  in  YEAR_W  binary year
- `month`  in  4  binary month
- `day`  in  5  binary day
- `sep`  in  2  separator code: 0 '.', 1 '-', 2 '/', 3 illegal
- `char`  out  8  ASCII character
- `char_valid`  out  1  `char` is valid
- `char_ready`  in  1  sink accepts `char`
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle pulse after the last character transfers
- `err`  out  1  one-cycle pulse when a start request is rejected

## Operation
- Reset values: `char`=8'h00, `char_valid`=0, `busy`=0, `done`=0, `err`=0, state=IDLE.
- **IDLE, `start`=1, all fields legal**
  - Legal means: year 1..9999, month 1..12, day 1..31, sep≠3.
  - The block latches all fields, sets `busy`, and enters CONV.
- **IDLE, `start`=1, any field illegal**
  - `err` pulses for one cycle; state stays IDLE; no characters are emitted.
- **`start` while `busy`=1**: ignored, with no effect on the current transaction.
- **CONV**
  - The year goes through a 14-iteration shift-add-3 conversion to 4 BCD digits, one iteration per cycle.
  - Month and day are split combinationally into tens and units digits (tens in 0..3).
- **LOAD** (one cycle)
  - Computes the first non-zero year digit index.
  - Drives the first year character and asserts `char_valid`.
- **YEAR**: emits year digits from the most significant non-zero digit down to the units digit.
- **SEP1**: emits the separator.
- **MON**: emits the month tens digit only if it is non-zero, then the units digit.
- **SEP2**: emits the separator.
- **DAY**: emits the day tens digit only if it is non-zero, then the units digit.
- **Exit**: after the final day digit transfers, the state returns to IDLE, `done` pulses, and `busy` clears.
- **Digit encoding**: a digit character is `8'h30 + digit`, a 4-bit value zero-extended to 8 bits.
- **String length**: 5..10 characters.

## Timing
- **Transfer rule**: a character transfers on a rising edge with `char_valid`&&`char_ready`=1.
  - While `char_valid`=1 and `char_ready`=0, `char` is held stable.
  - `char_valid` never drops without a transfer, except on reset.
- **Throughput**: one character per cycle when `char_ready` is held at 1; `char_valid` stays high across the whole string.
- **Start latency**
  - Edge 0 samples `start`; `busy`=1 after edge 0.
  - CONV iterates on edges 1..14.
  - LOAD occurs on edge 15, so `char_valid`=1 and the first character appear after edge 15.
- **Error latency**: `err` is high for exactly the cycle after the sampling edge.
- **Completion**: `done` and `busy`=0 appear after the edge that transfers the last character.
  - A new `start` is accepted in that same cycle, so it is sampled on the following edge.
- **Reset mid-operation**: returns to IDLE on that edge.
  - `char_valid`, `done` and `err` drop.
  - The partial string is abandoned, and no `done` follows.
- **Backpressure**: `char_ready` has no combinational path to `char` or `char_valid`.

## Structure
- Package `date_pkg` holds:
  - separator code constants and the sep→ASCII mapping function;
  - ASCII '0' base, '.', '-', '/';
  - the state enum: IDLE, CONV, LOAD, YEAR, SEP1, MON, SEP2, DAY;
  - month and day limits (12, 31) and the year limits (1, 9999).
- Sub-module `bin2bcd_seq` (parameter `W`=14, 4 BCD digits out) handles the year conversion.
  - Ports: `clk`, `reset`, `load`, `bin`, `bcd[15:0]`, `ready`.
  - `ready` rises exactly `W` cycles after `load`.
- The top level contains the FSM, the digit index counter (2 bits), and the field latches.

## Test plan
- **Full-length, no backpressure**: year=2024, month=12, day=31, sep=1, `char_ready`=1 → "2024-12-31".
  - 10 consecutive valid cycles with the first after edge 15; `done` one cycle after the '1' transfers.
- **Minimum length**: year=7, month=1, day=5, sep=0 → "7.1.5" (5 characters).
  - year=1000, month=10, day=10, sep=2 → "1000/10/10", confirming that internal zeros are kept.
- **Backpressure**: year=305, month=3, day=9, sep=0, with `char_ready` low 3 cycles on the '0' digit and random thereafter.
  - Output is "305.3.9"; `char` is stable while stalled; no characters are dropped or duplicated.
- **Illegal inputs**: month=13; then day=0; then year=0; then year=10000; then sep=3.
  - Each produces one `err` pulse, `busy`=0, and `char_valid` never rises.
- **Reset and ignored start**
  - Reset asserted after the 4th character of "2024-12-31": `char_valid`=0 the next cycle, no `done`, and a following start emits the full new string.
  - A `start` pulse mid-string leaves the output unchanged.

Source files
------------

// File: rtl/date_pkg.sv
// Shared constants, state encoding and ASCII helpers for the date-string transmitter.
package date_pkg;

  localparam logic [1:0] SEP_DOT   = 2'd0;
  localparam logic [1:0] SEP_DASH  = 2'd1;
  localparam logic [1:0] SEP_SLASH = 2'd2;
  localparam logic [1:0] SEP_ILL   = 2'd3;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;

  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t CONV = 3'd1;
  localparam state_t LOAD = 3'd2;
  localparam state_t YEAR = 3'd3;
  localparam state_t SEP1 = 3'd4;
  localparam state_t MON  = 3'd5;
  localparam state_t SEP2 = 3'd6;
  localparam state_t DAY  = 3'd7;

  localparam logic [3:0]  MONTH_MAX = 4'd12;
  localparam logic [4:0]  DAY_MAX   = 5'd31;
  localparam int unsigned YEAR_MIN  = 1;
  localparam int unsigned YEAR_MAX  = 9999;

  // The illegal code is rejected before latching, so it never reaches this mapping.
  function automatic logic [7:0] sep_ascii(input logic [1:0] s);
    case (s)
      SEP_DASH:  return ASCII_DASH;
      SEP_SLASH: return ASCII_SLASH;
      default:   return ASCII_DOT;
    endcase
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/date_string_tx_if.sv
// Request and character-stream signals of the date-string transmitter.
interface date_string_tx_if #(parameter int YEAR_W = 14);
  logic              start;
  logic [YEAR_W-1:0] year;
  logic [3:0]        month;
  logic [4:0]        day;
  logic [1:0]        sep;
  logic [7:0]        char;
  logic              char_valid;
  logic              char_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, year, month, day, sep, char_ready,
    output char, char_valid, busy, done, err
  );

  modport master (
    output start, year, month, day, sep, char_ready,
    input  char, char_valid, busy, done, err
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter, one iteration per clock.
module bin2bcd_seq #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] bin,
  output logic [15:0]  bcd,
  output logic         ready
);
  localparam int CNT_W = $clog2(W);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     sr;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Pulses during the cycle whose closing edge performs the final iteration.
  always_comb ready = active && (cnt == CNT_W'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      if (ready) active <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sr  <= bin;
      bcd <= '0;
    end else if (active) begin
      {bcd, sr} <= {add3(bcd), sr} << 1;
    end
  end

endmodule

// File: rtl/date_string_tx.sv
// Serialises a range-checked binary date as ASCII "Y<sep>M<sep>D" with no leading zeros.
module date_string_tx
  import date_pkg::*;
#(
  parameter int YEAR_W = 14
) (
  input logic             clk,
  input logic             reset,
  date_string_tx_if.slave bus
);
  localparam int BCD_W = 14;

  state_t            state;
  logic [1:0]        idx;
  logic [1:0]        first_idx;
  logic [1:0]        idx_dn;
  logic [3:0]        month_q;
  logic [4:0]        day_q;
  logic [1:0]        sep_q;
  logic [YEAR_W-1:0] year_in;
  logic [15:0]       bcd;
  logic              bcd_ready;
  logic              legal;
  logic              load;
  logic              xfer;
  logic [3:0]        mon_tens, mon_units, day_tens, day_units;

  function automatic logic [3:0] pick(input logic [15:0] b, input logic [1:0] i);
    return b[{i, 2'b00} +: 4];
  endfunction

  always_comb begin
    year_in = bus.year;
    legal   = (32'(year_in) >= YEAR_MIN) && (32'(year_in) <= YEAR_MAX) &&
              (bus.month != '0) && (bus.month <= MONTH_MAX) &&
              (bus.day != '0) && (bus.day <= DAY_MAX) && (bus.sep != SEP_ILL);
    load    = (state == IDLE) && bus.start && legal;
    xfer    = bus.char_valid && bus.char_ready;
    idx_dn  = idx - 2'd1;
  end

  always_comb begin
    mon_tens  = (month_q >= 4'd10) ? 4'd1 : 4'd0;
    mon_units = (month_q >= 4'd10) ? month_q - 4'd10 : month_q;
    if (day_q >= 5'd30) begin
      day_tens  = 4'd3;
      day_units = 4'(day_q - 5'd30);
    end else if (day_q >= 5'd20) begin
      day_tens  = 4'd2;
      day_units = 4'(day_q - 5'd20);
    end else if (day_q >= 5'd10) begin
      day_tens  = 4'd1;
      day_units = 4'(day_q - 5'd10);
    end else begin
      day_tens  = 4'd0;
      day_units = day_q[3:0];
    end
  end

  always_comb begin
    if (bcd[15:12] != '0)     first_idx = 2'd3;
    else if (bcd[11:8] != '0) first_idx = 2'd2;
    else if (bcd[7:4] != '0)  first_idx = 2'd1;
    else                      first_idx = 2'd0;
  end

  bin2bcd_seq #(.W(BCD_W)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .bin   (BCD_W'(year_in)),
    .bcd   (bcd),
    .ready (bcd_ready)
  );

  always_ff @(posedge clk) begin
    if (load) begin
      month_q <= bus.month;
      day_q   <= bus.day;
      sep_q   <= bus.sep;
    end
  end

  // Outputs are registered so char_ready never reaches char/char_valid combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      bus.char       <= 8'h00;
      bus.char_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (legal) begin
            bus.busy <= 1'b1;
            state    <= CONV;
          end else begin
            bus.err <= 1'b1;
          end
        end
        CONV: if (bcd_ready) state <= LOAD;
        LOAD: begin
          idx            <= first_idx;
          bus.char       <= ascii_digit(pick(bcd, first_idx));
          bus.char_valid <= 1'b1;
          state          <= YEAR;
        end
        YEAR: if (xfer) begin
          if (idx == 2'd0) begin
            bus.char <= sep_ascii(sep_q);
            state    <= SEP1;
          end else begin
            idx      <= idx_dn;
            bus.char <= ascii_digit(pick(bcd, idx_dn));
          end
        end
        SEP1: if (xfer) begin
          idx      <= (mon_tens != '0) ? 2'd1 : 2'd0;
          bus.char <= ascii_digit((mon_tens != '0) ? mon_tens : mon_units);
          state    <= MON;
        end
        MON: if (xfer) begin
          if (idx == 2'd1) begin
            idx      <= 2'd0;
            bus.char <= ascii_digit(mon_units);
          end else begin
            bus.char <= sep_ascii(sep_q);
            state    <= SEP2;
          end
        end
        SEP2: if (xfer) begin
          idx      <= (day_tens != '0) ? 2'd1 : 2'd0;
          bus.char <= ascii_digit((day_tens != '0) ? day_tens : day_units);
          state    <= DAY;
        end
        DAY: if (xfer) begin
          if (idx == 2'd1) begin
            idx      <= 2'd0;
            bus.char <= ascii_digit(day_units);
          end else begin
            bus.char_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
